// File: rtl/player_input_ctrl_pkg.sv
// player_input_ctrl_pkg: arbitration states, default board timing and a width helper
package player_input_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, HOLD_L, HOLD_R, WAIT_REL} state_t;
    localparam int CLK_HZ = 50_000_000;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_REPEAT_DELAY = 25_000_000;
    localparam int DEF_REPEAT_RATE = 7_500_000;
    function automatic int imax(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/player_input_ctrl_if.sv
// player_input_ctrl_if: raw buttons and enable in, move pulses and debounced levels out
interface player_input_ctrl_if;
    logic key_left_raw;
    logic key_right_raw;
    logic enable;
    logic left;
    logic right;
    logic left_held;
    logic right_held;
    modport master(
        input  key_left_raw, key_right_raw, enable,
        output left, right, left_held, right_held
    );
    modport slave(
        output key_left_raw, key_right_raw, enable,
        input  left, right, left_held, right_held
    );
endinterface

// File: rtl/player_input_ctrl_key_debounce.sv
// player_input_ctrl_key_debounce: 2-FF synchroniser plus persistence counter on a pressed=1 level
module player_input_ctrl_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic key,
    output logic db
);
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    logic s1, s2;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            db  <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= key;
            s2 <= s1;
            if (s2 == db) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                db  <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/player_input_ctrl.sv
// player_input_ctrl: turns two raw push-buttons into exclusive one-cycle left/right move pulses
// with hold auto-repeat; conflicting or enable-gated presses wait for a full release.
module player_input_ctrl
    import player_input_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input logic clk,
    input logic resetn,
    player_input_ctrl_if.master bus
);
    localparam int TW = $clog2(imax(REPEAT_DELAY, REPEAT_RATE));
    state_t state;
    logic [TW-1:0] timer;
    logic db_l, db_r, left_q, right_q, own, other;
    player_input_ctrl_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (
        .clk(clk), .resetn(resetn), .key(bus.key_left_raw ^ KEY_ACTIVE_LOW), .db(db_l)
    );
    player_input_ctrl_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (
        .clk(clk), .resetn(resetn), .key(bus.key_right_raw ^ KEY_ACTIVE_LOW), .db(db_r)
    );
    // own/other let HOLD_L and HOLD_R share one branch
    always_comb begin
        own   = state == HOLD_L ? db_l : db_r;
        other = state == HOLD_L ? db_r : db_l;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            timer   <= '0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
        end else begin
            left_q  <= 1'b0;
            right_q <= 1'b0;
            if (!bus.enable) begin
                state <= WAIT_REL;
                timer <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (db_l && db_r) begin
                            state <= WAIT_REL;
                        end else if (db_l || db_r) begin
                            left_q  <= db_l;
                            right_q <= db_r;
                            timer   <= TW'(REPEAT_DELAY - 1);
                            state   <= db_l ? HOLD_L : HOLD_R;
                        end
                    end
                    HOLD_L, HOLD_R: begin
                        if (!own || other) begin
                            state <= !own ? IDLE : WAIT_REL;
                            timer <= '0;
                        end else if (timer == '0) begin
                            left_q  <= state == HOLD_L;
                            right_q <= state == HOLD_R;
                            timer   <= TW'(REPEAT_RATE - 1);
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                    WAIT_REL: state <= (!db_l && !db_r) ? IDLE : WAIT_REL;
                    default:  state <= IDLE;
                endcase
            end
        end
    end
    assign bus.left       = left_q;
    assign bus.right      = right_q;
    assign bus.left_held  = db_l;
    assign bus.right_held = db_r;
endmodule

// File: tb/tb_player_input_ctrl.sv
// tb_player_input_ctrl: directed presses with expected pulse cycles queued for a negedge monitor
module tb_player_input_ctrl;
    typedef struct {int cyc; logic is_right;} pulse_t;
    typedef struct {int cyc; logic lh; logic rh;} held_t;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int cyc = 0;
    int compared = 0;
    int mismatched = 0;
    bit done = 1'b0;
    pulse_t pq[$];
    held_t hq[$];

    player_input_ctrl_if bus();

    player_input_ctrl #(
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(8), .KEY_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .resetn(resetn), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_pulse(input int c, input logic r);
        pq.push_back('{c, r});
    endtask

    task automatic exp_held(input int c, input logic lh, input logic rh);
        hq.push_back('{c, lh, rh});
    endtask

    always @(negedge clk) begin
        pulse_t e;
        held_t h;
        while (hq.size() > 0 && hq[0].cyc <= cyc) begin
            h = hq.pop_front();
            compared += 2;
            if (bus.left_held !== h.lh) begin
                mismatched++;
                $display("FAIL left_held @%0d: got %0b want %0b", cyc, bus.left_held, h.lh);
            end
            if (bus.right_held !== h.rh) begin
                mismatched++;
                $display("FAIL right_held @%0d: got %0b want %0b", cyc, bus.right_held, h.rh);
            end
        end
        if (bus.left === 1'b1 || bus.right === 1'b1) begin
            compared++;
            if (bus.left === 1'b1 && bus.right === 1'b1) begin
                mismatched++;
                $display("FAIL exclusive @%0d: left=1 right=1, want at most one", cyc);
            end else if (pq.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected pulse @%0d: right=%0b, want none", cyc, bus.right);
            end else begin
                e = pq.pop_front();
                if (e.cyc != cyc || e.is_right !== bus.right) begin
                    mismatched++;
                    $display("FAIL pulse: got cyc %0d right=%0b, want cyc %0d right=%0b",
                             cyc, bus.right, e.cyc, e.is_right);
                end
            end
        end
        if (done) begin
            while (pq.size() > 0) begin
                e = pq.pop_front();
                compared++;
                mismatched++;
                $display("FAIL missing pulse: got none, want cyc %0d right=%0b", e.cyc, e.is_right);
            end
            while (hq.size() > 0) begin
                h = hq.pop_front();
                compared++;
                mismatched++;
                $display("FAIL held check skipped: got none, want cyc %0d", h.cyc);
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
            $finish;
        end
    end

    initial begin
        int t;
        bus.key_left_raw = 1'b1;
        bus.key_right_raw = 1'b1;
        bus.enable = 1'b1;
        exp_held(1, 1'b0, 1'b0);
        exp_held(2, 1'b0, 1'b0);
        step(3);
        resetn = 1'b1;
        step(5);
        // clean press
        bus.key_left_raw = 1'b0;
        t = cyc;
        exp_held(t + 5, 1'b0, 1'b0);
        exp_held(t + 6, 1'b1, 1'b0);
        exp_pulse(t + 7, 1'b0);
        step(10);
        bus.key_left_raw = 1'b1;
        step(15);
        // bounce
        for (int i = 0; i < 6; i++) begin
            bus.key_left_raw = i[0];
            step(2);
        end
        bus.key_left_raw = 1'b0;
        t = cyc;
        exp_pulse(t + 7, 1'b0);
        step(10);
        bus.key_left_raw = 1'b1;
        step(15);
        // auto-repeat on right
        bus.key_right_raw = 1'b0;
        t = cyc;
        exp_pulse(t + 7, 1'b1);
        exp_pulse(t + 27, 1'b1);
        exp_pulse(t + 35, 1'b1);
        exp_pulse(t + 43, 1'b1);
        exp_pulse(t + 51, 1'b1);
        exp_pulse(t + 59, 1'b1);
        step(60);
        bus.key_right_raw = 1'b1;
        step(20);
        // conflict
        bus.key_left_raw = 1'b0;
        bus.key_right_raw = 1'b0;
        t = cyc;
        exp_held(t + 6, 1'b1, 1'b1);
        step(12);
        bus.key_left_raw = 1'b1;
        step(12);
        bus.key_right_raw = 1'b1;
        step(12);
        bus.key_right_raw = 1'b0;
        t = cyc;
        exp_pulse(t + 7, 1'b1);
        step(10);
        bus.key_right_raw = 1'b1;
        step(15);
        // enable gate
        bus.enable = 1'b0;
        step(2);
        bus.key_left_raw = 1'b0;
        step(15);
        bus.enable = 1'b1;
        step(30);
        bus.key_left_raw = 1'b1;
        step(12);
        bus.key_left_raw = 1'b0;
        t = cyc;
        exp_pulse(t + 7, 1'b0);
        step(10);
        bus.key_left_raw = 1'b1;
        step(15);
        // reset while the first pulse is on the output
        bus.key_left_raw = 1'b0;
        t = cyc;
        step(7);
        resetn = 1'b0;
        exp_held(t + 7, 1'b0, 1'b0);
        step(3);
        resetn = 1'b1;
        t = cyc;
        exp_pulse(t + 7, 1'b0);
        step(10);
        bus.key_left_raw = 1'b1;
        step(15);
        done = 1'b1;
        step(3);
        $display("FAIL monitor did not finish");
        $fatal(1);
    end
endmodule
